// File: rtl/pulse_sched.sv
// Round-robin scheduler granting one shared fixed-width pulse to NUM_REQ latched requesters.
// Optional statistics counters are compiled in when PULSE_SCHED_STATS_EN is defined.
module pulse_sched #(
    parameter int NUM_REQ      = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         sig_in,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       pulse_out,
    output logic [$clog2(NUM_REQ)-1:0] pulse_owner,
    output logic                       pulse_done
`ifdef PULSE_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_pulses,
    output logic [31:0]                stat_coalesced
`endif
);

    localparam int OWN_W   = $clog2(NUM_REQ);
    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [OWN_W-1:0]   rr_ptr;
    logic               grant;
    logic [OWN_W-1:0]   winner;
    logic [NUM_REQ-1:0] grant_mask;
    logic [NUM_REQ-1:0] pending_next;

    // Scanning from the farthest candidate down lets the nearest set bit after ptr win.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [OWN_W-1:0]   ptr);
        logic [OWN_W-1:0] pick;
        pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) pick = OWN_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        grant        = (state == IDLE) && enable && (|pending);
        winner       = rr_pick(pending, rr_ptr);
        grant_mask   = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
        // A request arriving on its own grant edge survives the clear.
        pending_next = (pending & ~grant_mask) | sig_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            pulse_out   <= 1'b0;
            pulse_done  <= 1'b0;
            pulse_owner <= '0;
            rr_ptr      <= OWN_W'(NUM_REQ - 1);
        end else begin
            pending    <= pending_next;
            pulse_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        pulse_owner <= winner;
                        rr_ptr      <= winner;
                        pulse_out   <= 1'b1;
                        cnt         <= '0;
                        state       <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        pulse_out  <= 1'b0;
                        pulse_done <= 1'b1;
                        cnt        <= '0;
                        state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PULSE_SCHED_STATS_EN
    logic [NUM_REQ-1:0] coalesced_bits;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [NUM_REQ-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < NUM_REQ; i++) n = n + {31'd0, v[i]};
        return n;
    endfunction

    assign coalesced_bits = sig_in & pending & ~grant_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pulses    <= '0;
            stat_coalesced <= '0;
        end else begin
            stat_pulses    <= sat_add(stat_pulses, {31'd0, grant});
            stat_coalesced <= sat_add(stat_coalesced, popcount(coalesced_bits));
        end
    end
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// Scoreboard bench for pulse_sched (NUM_REQ=4, PULSE_CYCLES=3, GAP_CYCLES=2).
module tb_pulse_sched;

    localparam int NR = 4;
    localparam int PC = 3;
    localparam int GC = 2;
    localparam int SPACING = PC + GC + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NR-1:0] sig_in;
    logic [NR-1:0] pending;
    logic          pulse_out;
    logic [1:0]    pulse_owner;
    logic          pulse_done;
`ifdef PULSE_SCHED_STATS_EN
    logic [31:0]   stat_pulses;
    logic [31:0]   stat_coalesced;
`endif

    pulse_sched #(.NUM_REQ(NR), .PULSE_CYCLES(PC), .GAP_CYCLES(GC)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sig_in         (sig_in),
        .pending        (pending),
        .pulse_out      (pulse_out),
        .pulse_owner    (pulse_owner),
        .pulse_done     (pulse_done)
`ifdef PULSE_SCHED_STATS_EN
        ,
        .stat_pulses    (stat_pulses),
        .stat_coalesced (stat_coalesced)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] owner;
        int         start;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]      req;
        int              n;
        logic [3:0][1:0] own;
    } vec_t;
    vec_t vecs[6];

    function automatic vec_t mk(input logic [3:0] r, input int n,
                                input logic [1:0] o0, input logic [1:0] o1,
                                input logic [1:0] o2, input logic [1:0] o3);
        vec_t v;
        v.req    = r;
        v.n      = n;
        v.own[0] = o0;
        v.own[1] = o1;
        v.own[2] = o2;
        v.own[3] = o3;
        return v;
    endfunction

    int   exp_width = PC;
    logic exp_done  = 1'b1;
    logic mon_en    = 1'b0;
    logic prev_pulse = 1'b0;
    int   width = 0;

    // Pulse monitor: pops the scoreboard on each rising edge of pulse_out.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pulse_out === 1'b1 && !prev_pulse) begin
                check("pulse_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_owner", pulse_owner, e.owner);
                    check("pulse_start", cyc, e.start);
                end
                width = 0;
            end
            if (pulse_out === 1'b1) width++;
            if (pulse_out !== 1'b1 && prev_pulse) begin
                check("pulse_width", width, exp_width);
                check("pulse_done", pulse_done, exp_done);
            end else if (pulse_done !== 1'b0) begin
                check("stray_done", pulse_done, 0);
            end
            prev_pulse = (pulse_out === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || pulse_out === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_time", n < budget, 1);
        sb.delete();
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int e;

        vecs[0] = mk(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);
        vecs[1] = mk(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[2] = mk(4'b1111, 4, 2'd3, 2'd0, 2'd1, 2'd2);
        vecs[3] = mk(4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
        vecs[4] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[5] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);

        reset  = 1'b1;
        enable = 1'b1;
        sig_in = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_pending", pending, 0);
        check("rst_pulse_out", pulse_out, 0);
        check("rst_owner", pulse_owner, 0);
        check("rst_done", pulse_done, 0);
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Table-driven single-strobe patterns; order reflects the rotating pointer.
        for (int i = 0; i < 6; i++) begin
            tick();
            sig_in = vecs[i].req;
            c = cyc;
            for (int k = 0; k < vecs[i].n; k++)
                sb.push_back('{vecs[i].own[k], c + 2 + SPACING * k});
            tick();
            sig_in = '0;
            @(negedge clk);
            check("vec_pending_latched", pending, vecs[i].req);
            drain(100);
            check("vec_pending_clear", pending, 0);
        end

        // enable low holds requests; dropping it mid-pulse must not truncate.
        do_reset();
        enable = 1'b0;
        tick();
        sig_in = 4'b0011;
        tick();
        sig_in = '0;
        repeat (20) begin
            @(negedge clk);
            check("hold_no_pulse", pulse_out, 0);
            tick();
        end
        @(negedge clk);
        check("hold_pending", pending, 4'b0011);
        tick();
        enable = 1'b1;
        e = cyc;
        sb.push_back('{2'd0, e + 1});
        tick();
        tick();
        enable = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("gated_pending", pending, 4'b0010);
        check("gated_queue_empty", sb.size(), 0);
        tick();
        enable = 1'b1;
        e = cyc;
        sb.push_back('{2'd1, e + 1});
        drain(100);

        // Repeated strobes while pending coalesce into a single pulse.
        do_reset();
        enable = 1'b0;
        tick();
        sig_in = 4'b0010;
        repeat (3) tick();
        sig_in = '0;
        tick();
        enable = 1'b1;
        e = cyc;
        sb.push_back('{2'd1, e + 1});
        drain(100);
        check("coalesce_pending", pending, 0);
`ifdef PULSE_SCHED_STATS_EN
        check("coalesce_stat_pulses", stat_pulses, 1);
        check("coalesce_stat_coalesced", stat_coalesced, 2);
`endif

        // Strobe on the grant edge re-arms the same requester.
        do_reset();
        enable = 1'b1;
        tick();
        sig_in = 4'b0001;
        c = cyc;
        sb.push_back('{2'd0, c + 2});
        sb.push_back('{2'd0, c + 2 + SPACING});
        tick();
        tick();
        sig_in = '0;
        @(negedge clk);
        check("setwins_pending", pending, 4'b0001);
        drain(100);
        check("setwins_pending_clear", pending, 0);
`ifdef PULSE_SCHED_STATS_EN
        check("setwins_stat_pulses", stat_pulses, 2);
        check("setwins_stat_coalesced", stat_coalesced, 0);
`endif

        // Reset in the second pulse cycle kills the pulse and pending requests.
        do_reset();
        tick();
        sig_in = 4'b0110;
        c = cyc;
        sb.push_back('{2'd1, c + 2});
        exp_width = 2;
        exp_done  = 1'b0;
        tick();
        sig_in = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_pulse_out", pulse_out, 0);
        check("midrst_pending", pending, 0);
        check("midrst_done", pulse_done, 0);
        check("midrst_owner", pulse_owner, 0);
        tick();
        exp_width = PC;
        exp_done  = 1'b1;
        check("midrst_queue_empty", sb.size(), 0);
        tick();
        sig_in = 4'b0100;
        c = cyc;
        sb.push_back('{2'd2, c + 2});
        tick();
        sig_in = '0;
        drain(100);
        check("post_rst_owner", pulse_owner, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
